// File: rtl/fram_access_arbiter.sv
// Purpose: round-robin sequencer sharing one i2c_master between two single-byte FRAM requesters.
// Latency: acceptance edge -> cmd_valid next cycle; resp_valid 5 cycles after acceptance (write), 6 (read).
// Backpressure: each cmd/tx/rx beat is held until its ready; req_ready only in IDLE while i2c_busy=0.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata  per-port single-byte request (index 0 = debug switches, 1 = UART bridge)
//   resp_valid/err, resp_rdata     per-port one-cycle completion; shared read byte held until next read
//   cmd_*                          i2c_master command channel
//   tx_*                           i2c_master s_axis_data (write bytes)
//   rx_*                           i2c_master m_axis_data (read bytes)
//   i2c_busy, i2c_missed_ack       i2c_master status
module fram_access_arbiter #(
    parameter logic [2:0]  DEV_ADDR       = 3'b000,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [1:0][7:0] req_addr,
    input  logic [1:0][7:0] req_wdata,
    output logic [1:0]      resp_valid,
    output logic [1:0]      resp_err,
    output logic [7:0]      resp_rdata,
    output logic [6:0]      cmd_address,
    output logic            cmd_start,
    output logic            cmd_read,
    output logic            cmd_write_multiple,
    output logic            cmd_stop,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [7:0]      tx_tdata,
    output logic            tx_tvalid,
    output logic            tx_tlast,
    input  logic            tx_tready,
    input  logic [7:0]      rx_tdata,
    input  logic            rx_tvalid,
    output logic            rx_tready,
    input  logic            i2c_busy,
    input  logic            i2c_missed_ack
);

    typedef enum logic [2:0] {
        IDLE, CMD_WR, ADDR, DATA_WR, CMD_RD, DATA_RD, CMD_STOP, RESP
    } state_t;

    localparam logic [6:0] I2C_ADDR = {4'b1010, DEV_ADDR};

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        grant;
    logic        lat_we;
    logic [7:0]  lat_addr;
    logic [7:0]  lat_wdata;
    logic        err;
    logic [19:0] wd_cnt;

    logic        grant_sel;
    logic        can_grant;
    logic        watched;
    logic        wd_timeout;

    // Arbitration: on a tie the port not served last wins.
    always_comb begin
        grant_sel = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_sel = ~last_grant;
        end
        can_grant = (state == IDLE) && !i2c_busy && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (can_grant) begin
            req_ready = grant_sel ? 2'b10 : 2'b01;
        end
    end

    // Watchdog only runs while waiting on the i2c_master; a zero limit disables it.
    assign watched    = (state != IDLE) && (state != RESP);
    assign wd_timeout = (TIMEOUT_CYCLES != 20'd0) && watched &&
                        (wd_cnt == TIMEOUT_CYCLES - 20'd1);

    // Priority inside a state: missed ACK abort, then the handshake, then the watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (can_grant) state_nxt = CMD_WR;
            CMD_WR: begin
                if (cmd_ready)       state_nxt = ADDR;
                else if (wd_timeout) state_nxt = CMD_STOP;
            end
            ADDR: begin
                if (i2c_missed_ack)  state_nxt = CMD_STOP;
                else if (tx_tready)  state_nxt = lat_we ? DATA_WR : CMD_RD;
                else if (wd_timeout) state_nxt = CMD_STOP;
            end
            DATA_WR: begin
                if (i2c_missed_ack || tx_tready || wd_timeout) state_nxt = CMD_STOP;
            end
            CMD_RD: begin
                if (i2c_missed_ack)  state_nxt = CMD_STOP;
                else if (cmd_ready)  state_nxt = DATA_RD;
                else if (wd_timeout) state_nxt = CMD_STOP;
            end
            DATA_RD: begin
                if (i2c_missed_ack || rx_tvalid || wd_timeout) state_nxt = CMD_STOP;
            end
            CMD_STOP: begin
                if (cmd_ready || wd_timeout) state_nxt = RESP;
            end
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
            err        <= 1'b0;
            wd_cnt     <= 20'd0;
            resp_rdata <= 8'h00;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                wd_cnt <= 20'd0;
            end else if (watched) begin
                wd_cnt <= wd_cnt + 20'd1;
            end

            if (state == IDLE) begin
                if (can_grant) begin
                    grant     <= grant_sel;
                    lat_we    <= req_we[grant_sel];
                    lat_addr  <= req_addr[grant_sel];
                    lat_wdata <= req_wdata[grant_sel];
                    err       <= 1'b0;
                end
            end else if (i2c_missed_ack || wd_timeout) begin
                err <= 1'b1;
            end

            // A byte that arrives together with a missed ACK is discarded.
            if (state == DATA_RD && rx_tvalid && !i2c_missed_ack) begin
                resp_rdata <= rx_tdata;
            end

            if (state == RESP) begin
                last_grant <= grant;
            end
        end
    end

    // Interface decodes: everything is zero outside the state that owns it.
    always_comb begin
        cmd_valid          = (state == CMD_WR) || (state == CMD_RD) || (state == CMD_STOP);
        cmd_start          = (state == CMD_WR) || (state == CMD_RD);
        cmd_write_multiple = (state == CMD_WR);
        cmd_read           = (state == CMD_RD);
        cmd_stop           = (state == CMD_STOP);
        cmd_address        = cmd_valid ? I2C_ADDR : 7'h00;

        tx_tvalid = (state == ADDR) || (state == DATA_WR);
        tx_tlast  = ((state == ADDR) && !lat_we) || (state == DATA_WR);
        tx_tdata  = 8'h00;
        if (state == ADDR)    tx_tdata = lat_addr;
        if (state == DATA_WR) tx_tdata = lat_wdata;

        rx_tready = (state == DATA_RD);

        resp_valid = 2'b00;
        if (state == RESP) begin
            resp_valid = grant ? 2'b10 : 2'b01;
        end
        resp_err = resp_valid & {2{err}};
    end

endmodule

// File: tb/tb_fram_access_arbiter.sv
module tb_fram_access_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0][7:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      resp_valid;
    logic [1:0]      resp_err;
    logic [7:0]      resp_rdata;
    logic [6:0]      cmd_address;
    logic            cmd_start, cmd_read, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
    logic [7:0]      tx_tdata;
    logic            tx_tvalid, tx_tlast, tx_tready;
    logic [7:0]      rx_tdata;
    logic            rx_tvalid, rx_tready;
    logic            i2c_busy, i2c_missed_ack;

    // i2c_master stand-in controls
    logic cmd_rdy_en, tx_rdy_en, rx_vld_en, busy, nack;
    assign cmd_ready      = cmd_rdy_en;
    assign tx_tready      = tx_rdy_en;
    assign rx_tvalid      = rx_vld_en;
    assign i2c_busy       = busy;
    assign i2c_missed_ack = nack;

    fram_access_arbiter #(.DEV_ADDR(3'b000), .TIMEOUT_CYCLES(20'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack)
    );

    always #5 clk = ~clk;

    // Tiny FRAM model: first tx byte after a start is the word address, the next is data.
    logic [7:0]  mem [256];
    logic [7:0]  ptr;
    int          beat;
    logic [10:0] cmd_log [$];   // {address, start, read, write_multiple, stop}
    logic [8:0]  tx_log  [$];   // {tdata, tlast}
    assign rx_tdata = mem[ptr];

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            cmd_log.push_back({cmd_address, cmd_start, cmd_read, cmd_write_multiple, cmd_stop});
            if (cmd_start) beat <= 0;
        end
        if (tx_tvalid && tx_tready) begin
            tx_log.push_back({tx_tdata, tx_tlast});
            if (beat == 0) ptr <= tx_tdata;
            else           mem[ptr] <= tx_tdata;
            beat <= beat + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_ready"},  32'(req_ready), 32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_err"},   32'(resp_err), 32'd0);
        chk({tag, " resp_rdata"}, 32'(resp_rdata), 32'd0);
        chk({tag, " cmd"}, 32'({cmd_address, cmd_start, cmd_read, cmd_write_multiple, cmd_stop, cmd_valid}), 32'd0);
        chk({tag, " tx"},  32'({tx_tdata, tx_tvalid, tx_tlast}), 32'd0);
        chk({tag, " rx_tready"},  32'(rx_tready), 32'd0);
    endtask

    // Issue one request, wait for acceptance, return values seen in the RESP cycle.
    task automatic do_txn(input int port, input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          output int lat, output logic [1:0] rv, output logic [1:0] re, output logic [7:0] rd);
        logic acc;
        acc = 1'b0; lat = -1; rv = 2'b00; re = 2'b00; rd = 8'h00;
        @(negedge clk);
        req_valid[port] = 1'b1; req_we[port] = we; req_addr[port] = addr; req_wdata[port] = wdata;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (req_ready[port]) acc = 1'b1;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[port] = 1'b0;
        if (acc) begin
            for (int n = 1; n <= 40; n++) begin
                #1;
                if (resp_valid != 2'b00) begin
                    lat = n; rv = resp_valid; re = resp_err; rd = resp_rdata;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [1:0] vld;
        logic       bsy;
        logic [1:0] exp_rdy;
    } arb_vec_t;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } txn_vec_t;

    arb_vec_t arb_tab [6];
    txn_vec_t txn_tab [4];

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int       lat, c0, t0, ntx, ncmd, ns, np, ng;
        logic [1:0] rv, re;
        logic [7:0] rd;
        int       g_port [3];
        int       g_cyc  [3];

        arb_tab[0] = '{2'b00, 1'b0, 2'b00};
        arb_tab[1] = '{2'b01, 1'b0, 2'b01};
        arb_tab[2] = '{2'b10, 1'b0, 2'b10};
        arb_tab[3] = '{2'b11, 1'b0, 2'b01};   // last-grant resets to 1 -> port 0 wins
        arb_tab[4] = '{2'b11, 1'b1, 2'b00};
        arb_tab[5] = '{2'b10, 1'b1, 2'b00};

        txn_tab[0] = '{0, 1'b1, 8'h04, 8'hA5, 1'b0, 8'h00, 5};
        txn_tab[1] = '{1, 1'b0, 8'h04, 8'h00, 1'b0, 8'hA5, 6};
        txn_tab[2] = '{0, 1'b1, 8'h10, 8'h3C, 1'b0, 8'hA5, 5};
        txn_tab[3] = '{1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C, 6};

        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        cmd_rdy_en = 1'b1; tx_rdy_en = 1'b1; rx_vld_en = 1'b1; busy = 1'b0; nack = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Combinational arbitration, request withdrawn before the edge so nothing starts.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = arb_tab[i].vld; busy = arb_tab[i].bsy;
            #1 chk($sformatf("arb[%0d] req_ready", i), 32'(req_ready), 32'(arb_tab[i].exp_rdy));
            #1 req_valid = 2'b00; busy = 1'b0;
        end
        @(negedge clk);
        #1 chk("no_txn_after_withdraw cmd_valid", 32'(cmd_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            c0 = cmd_log.size(); t0 = tx_log.size();
            do_txn(txn_tab[i].port, txn_tab[i].we, txn_tab[i].addr, txn_tab[i].wdata, lat, rv, re, rd);
            chk($sformatf("txn[%0d] latency", i), 32'(lat), 32'(txn_tab[i].exp_lat));
            chk($sformatf("txn[%0d] resp_valid", i), 32'(rv), txn_tab[i].port == 1 ? 32'd2 : 32'd1);
            chk($sformatf("txn[%0d] resp_err", i), 32'(re), 32'(txn_tab[i].exp_err ? rv : 2'b00));
            chk($sformatf("txn[%0d] resp_rdata", i), 32'(rd), 32'(txn_tab[i].exp_rdata));
            ntx  = tx_log.size() - t0;
            ncmd = cmd_log.size() - c0;
            chk($sformatf("txn[%0d] tx beats", i), 32'(ntx), txn_tab[i].we ? 32'd2 : 32'd1);
            chk($sformatf("txn[%0d] tx addr beat", i), 32'(tx_log[t0]), 32'({txn_tab[i].addr, ~txn_tab[i].we}));
            if (txn_tab[i].we && ntx >= 2)
                chk($sformatf("txn[%0d] tx data beat", i), 32'(tx_log[t0+1]), 32'({txn_tab[i].wdata, 1'b1}));
            chk($sformatf("txn[%0d] cmd count", i), 32'(ncmd), txn_tab[i].we ? 32'd2 : 32'd3);
            chk($sformatf("txn[%0d] cmd start write", i), 32'(cmd_log[c0]), 32'({7'h50, 4'b1010}));
            if (!txn_tab[i].we && ncmd >= 3)
                chk($sformatf("txn[%0d] cmd start read", i), 32'(cmd_log[c0+1]), 32'({7'h50, 4'b1100}));
            if (ncmd >= 1)
                chk($sformatf("txn[%0d] cmd stop", i), 32'(cmd_log[c0+ncmd-1]), 32'({7'h50, 4'b0001}));
        end

        // Both ports requesting continuously: 0, 1, 0, re-grant the cycle after RESP.
        @(negedge clk);
        req_we = 2'b11; req_addr = {8'h31, 8'h30}; req_wdata = {8'h22, 8'h11};
        req_valid = 2'b11;
        ng = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                g_port[ng] = req_ready[1] ? 1 : 0;
                g_cyc[ng]  = c;
                ng++;
                if (ng == 3) break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        chk("tie grant count", 32'(ng), 32'd3);
        chk("tie grant0 port", 32'(g_port[0]), 32'd0);
        chk("tie grant1 port", 32'(g_port[1]), 32'd1);
        chk("tie grant2 port", 32'(g_port[2]), 32'd0);
        chk("tie regrant gap1", 32'(g_cyc[1] - g_cyc[0]), 32'd6);
        chk("tie regrant gap2", 32'(g_cyc[2] - g_cyc[1]), 32'd6);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (resp_valid != 2'b00) break;
            @(negedge clk);
        end
        chk("tie final resp_valid", 32'(resp_valid), 32'd1);

        // Address NACK: abort straight to stop, no data beat, error, read data kept.
        @(negedge clk);
        tx_rdy_en = 1'b0;
        t0 = tx_log.size();
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 8'h20; req_wdata[1] = 8'h77;
        #1 chk("nack req_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        #1 chk("nack ADDR beat", 32'({tx_tvalid, tx_tdata, tx_tlast}), 32'({1'b1, 8'h20, 1'b0}));
        nack = 1'b1;
        @(negedge clk);
        nack = 1'b0;
        #1 chk("nack stop cmd", 32'({cmd_valid, cmd_stop, tx_tvalid}), 32'({1'b1, 1'b1, 1'b0}));
        tx_rdy_en = 1'b1;
        @(negedge clk);
        #1 chk("nack resp_valid", 32'(resp_valid), 32'd2);
        chk("nack resp_err", 32'(resp_err), 32'd2);
        chk("nack resp_rdata", 32'(resp_rdata), 32'h3C);
        chk("nack tx beats", 32'(tx_log.size() - t0), 32'd0);

        // Watchdog: cmd_ready stuck low, 16 cycles in CMD_WR then 16 in CMD_STOP.
        @(negedge clk);
        cmd_rdy_en = 1'b0;
        t0 = tx_log.size();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h40; req_wdata[0] = 8'h55;
        #1 chk("wd req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        ns = 0; np = 0; rv = 2'b00; re = 2'b00;
        for (int n = 1; n <= 40; n++) begin
            #1;
            if (cmd_valid && cmd_start) ns++;
            if (cmd_valid && cmd_stop)  np++;
            if (resp_valid != 2'b00) begin rv = resp_valid; re = resp_err; break; end
            @(negedge clk);
        end
        cmd_rdy_en = 1'b1;
        chk("wd CMD_WR cycles", 32'(ns), 32'd16);
        chk("wd CMD_STOP cycles", 32'(np), 32'd16);
        chk("wd resp_valid", 32'(rv), 32'd1);
        chk("wd resp_err", 32'(re), 32'd1);
        chk("wd tx beats", 32'(tx_log.size() - t0), 32'd0);

        // Reset in the middle of DATA_RD.
        @(negedge clk);
        rx_vld_en = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'h04;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rx_tready) break;
            @(negedge clk);
        end
        chk("rst reached DATA_RD", 32'(rx_tready), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1; rx_vld_en = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("post-reset tie grant", 32'(req_ready), 32'd1);
        #1 req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fram_access_arbiter.md
# fram_access_arbiter

Arbitrating sequencer that shares one `i2c_master` (AXI-stream command/data interface) between two single-byte FRAM requesters (port 0: debug switches, port 1: UART bridge). It grants one request at a time using round-robin and drives the full FM24CLxx transaction:

- start + device address,
- memory address,
- data write or repeated-start read,
- stop.

It then returns a one-cycle response with the read data and an error flag.

## Interface
Parameters:
- DEV_ADDR, 3'b000, FM24CLxx strap bits; the I2C address is {4'b1010, DEV_ADDR}.
- TIMEOUT_CYCLES, 20'd1000000, per-state watchdog limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid[n], n=0,1  in  1  request pending on port n.
- req_ready[n]  out  1  request accepted this cycle.
- req_we[n]  in  1  1=write, 0=read.
- req_addr[n]  in  8  FRAM word address.
- req_wdata[n]  in  8  write byte.
- resp_valid[n]  out  1  one-cycle completion pulse on port n.
- resp_err[n]  out  1  1 = missed ACK or timeout; valid with resp_valid[n].
- resp_rdata  out  8  read byte, shared by both ports; held until the next read completes.
- cmd_address  out  7  to i2c_master.
- cmd_start, cmd_read, cmd_write_multiple, cmd_stop  out  1 each  to i2c_master.
- cmd_valid  out  1  to i2c_master.
- cmd_ready  in  1  from i2c_master.
- tx_tdata  out  8  to i2c_master s_axis_data.
- tx_tvalid, tx_tlast  out  1 each  to i2c_master s_axis_data.
- tx_tready  in  1  from i2c_master s_axis_data.
- rx_tdata  in  8  from i2c_master m_axis_data.
- rx_tvalid  in  1  from i2c_master m_axis_data.
- rx_tready  out  1  to i2c_master m_axis_data.
- i2c_busy, i2c_missed_ack  in  1 each  i2c_master status.

## Operation
- Internal FSM states: IDLE, CMD_WR, ADDR, DATA_WR, CMD_RD, DATA_RD, CMD_STOP, RESP.
- IDLE arbitration:
  - Grant when any req_valid is high and i2c_busy=0.
  - If both ports request, grant the port not granted last.
  - The last-grant register resets to 1, so port 0 wins the first tie.
  - req_ready[g] is a combinational pulse in IDLE for the granted port only.
  - On acceptance, latch g, we, addr and wdata; clear the error flag; go to CMD_WR.
- CMD_WR: cmd_valid=1, cmd_start=1, cmd_write_multiple=1, cmd_address={4'b1010,DEV_ADDR}. Advance to ADDR when cmd_ready=1.
- ADDR: tx_tvalid=1, tx_tdata=latched addr, tx_tlast=~we. On tx_tready, go to DATA_WR if we=1, else CMD_RD.
- DATA_WR: tx_tvalid=1, tx_tdata=wdata, tx_tlast=1. On tx_tready, go to CMD_STOP.
- CMD_RD: cmd_valid=1, cmd_start=1, cmd_read=1, same cmd_address. On cmd_ready, go to DATA_RD.
- DATA_RD: rx_tready=1. On rx_tvalid, latch rx_tdata into resp_rdata and go to CMD_STOP.
- CMD_STOP: cmd_valid=1, cmd_stop=1, same cmd_address. On cmd_ready, go to RESP.
- RESP:
  - resp_valid[g]=1 and resp_err[g]=error flag, for exactly one cycle.
  - Update last-grant to g; return to IDLE.
- Error flag:
  - Set by i2c_missed_ack=1 in any non-IDLE state.
  - If set in ADDR, DATA_WR, CMD_RD or DATA_RD, the FSM jumps straight to CMD_STOP; pending tx/rx beats are abandoned and resp_rdata is not updated.
- Watchdog:
  - A counter clears on every state change and counts while in a non-IDLE, non-RESP state.
  - On reaching TIMEOUT_CYCLES-1, set the error flag: from CMD_STOP go to RESP, from any other state go to CMD_STOP.
- All cmd/tx/rx outputs are combinational decodes of state and latched fields; they are 0 when not in the listed state.

## Timing
- Reset values: state=IDLE, last-grant=1, resp_rdata=8'h00, error flag=0, watchdog counter=0.
- After reset, all outputs are 0 (req_ready, resp_*, cmd_*, tx_*, rx_tready).
- Reset asserted mid-transaction returns to IDLE immediately; no stop is issued, and i2c_master is reset by the same reset.
- Request-to-command latency:
  - Acceptance edge (req_valid & req_ready) moves IDLE→CMD_WR.
  - cmd_valid is asserted in the next cycle.
- Handshakes follow AXI-stream:
  - valid is held until ready.
  - data and flags are stable while valid=1.
  - A transfer occurs on the edge where both are high.
- With ready always high, a write visits CMD_WR, ADDR, DATA_WR, CMD_STOP, RESP.
  - resp_valid is asserted 5 cycles after acceptance.
- A read visits CMD_WR, ADDR, CMD_RD, DATA_RD, CMD_STOP, RESP, adding one cycle beyond the write path.
- No new grant in the RESP cycle; the earliest re-grant is the cycle after RESP.
- If req_valid drops before req_ready, no transaction starts.

## Test plan
- Port 0 write, addr 8'h04, wdata 8'hA5, I2C slave model ACKs all bytes:
  - cmd_address=7'h50 with write_multiple;
  - tx beats 8'h04 (tlast=0) then 8'hA5 (tlast=1);
  - stop command;
  - resp_valid[0] pulse with resp_err=0.
- Port 1 read of addr 8'h04 after that write:
  - tx beat 8'h04 with tlast=1;
  - repeated-start read command;
  - resp_rdata=8'hA5 and resp_valid[1] with err=0.
- Both ports request at the same cycle, twice in a row: port 0 is granted first, then port 1, then port 0.
- Slave NACKs the device address (i2c_missed_ack pulse during ADDR):
  - FSM goes to CMD_STOP without a data beat;
  - resp_err=1;
  - resp_rdata unchanged.
- TIMEOUT_CYCLES=16 with cmd_ready tied to 0:
  - error at cycle 16 of CMD_WR and move to CMD_STOP;
  - a second timeout there leads to RESP with resp_err=1.
- rst_n pulsed low during DATA_RD:
  - all outputs 0 asynchronously;
  - state=IDLE;
  - resp_rdata=8'h00.
